// File: rtl/skid_buffer.sv
// skid_buffer: two-entry registered valid/ready pipeline stage.
//
// Purpose: breaks the combinational ready path between upstream and
// downstream while sustaining one transfer per clock. All outputs come
// straight from flops. A second (skid) register catches the word that
// arrives on the edge where downstream stalls, because the upstream side
// only learns about the stall one clock later through in_ready.
//
// Ports:
//   aclk       clock, rising edge
//   areset     synchronous active-high reset
//   in_data    upstream payload       (DATA_WIDTH)
//   in_valid   upstream payload valid
//   in_ready   block can accept a payload (registered)
//   out_data   downstream payload     (DATA_WIDTH, registered)
//   out_valid  downstream payload valid (registered)
//   out_ready  downstream accepts payload
//   sts_count  32-bit count of downstream transfers, wraps; only present
//              when the macro SKID_BUFFER_COUNT_EN is defined
//
// Configuration macro: SKID_BUFFER_COUNT_EN (optional transfer counter).
module skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SKID_BUFFER_COUNT_EN
  ,
  output logic [31:0]           sts_count
`endif
);

  // EMPTY: nothing held; BUSY: output reg full; FULL: output and skid full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] skid_data;

  logic up_xfer, dn_xfer;
  logic or_from_in, or_from_sr, sr_load;
  logic in_ready_nx, out_valid_nx;

  assign up_xfer = in_valid & in_ready;
  assign dn_xfer = out_valid & out_ready;

  // State register. in_ready is forced low during reset so nothing can be
  // accepted until the first edge after reset is released.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (up_xfer) state_nx = BUSY;
      BUSY: begin
        if (up_xfer && !dn_xfer)      state_nx = FULL;
        else if (!up_xfer && dn_xfer) state_nx = EMPTY;
      end
      FULL:    if (dn_xfer) state_nx = BUSY;
      default: state_nx = EMPTY;
    endcase
  end

  // Output / datapath control. Handshake flags are registered versions of
  // the next state so both outputs stay glitch-free flop outputs.
  always_comb begin
    or_from_in   = 1'b0;
    or_from_sr   = 1'b0;
    sr_load      = 1'b0;
    case (state)
      EMPTY:   or_from_in = up_xfer;
      BUSY: begin
        or_from_in = up_xfer & dn_xfer;
        sr_load    = up_xfer & ~dn_xfer;
      end
      FULL:    or_from_sr = dn_xfer;
      default: ;
    endcase
    in_ready_nx  = (state_nx != FULL);
    out_valid_nx = (state_nx != EMPTY);
  end

  // Payload registers carry no reset; their contents only matter when the
  // matching valid state says so.
  always_ff @(posedge aclk) begin
    if (or_from_in)      out_data <= in_data;
    else if (or_from_sr) out_data <= skid_data;
    if (sr_load)         skid_data <= in_data;
  end

`ifdef SKID_BUFFER_COUNT_EN
  always_ff @(posedge aclk) begin
    if (areset)       sts_count <= 32'd0;
    else if (dn_xfer) sts_count <= sts_count + 32'd1;
  end
`endif

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 The parameter list SHALL be: DATA_WIDTH, default 32, width of in_data and out_data in bits.
REQ-002 aclk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 areset  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  DATA_WIDTH  upstream stream payload.
REQ-005 in_valid  input  1  upstream payload valid.
REQ-006 in_ready  output  1  block accepts upstream payload; driven directly from a register.
REQ-007 out_data  output  DATA_WIDTH  downstream payload; driven directly from a register.
REQ-008 out_valid  output  1  downstream payload valid; driven directly from a register.
REQ-009 out_ready  input  1  downstream accepts payload.
REQ-010 sts_count  output  32  count of downstream transfers; present only per REQ-026.

Function
REQ-011 An upstream transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; a downstream transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-012 The block SHALL hold two payload registers, output register (OR) and skid register (SR), and a 3-state FSM: EMPTY (OR, SR empty), BUSY (OR full, SR empty), FULL (OR, SR full).
REQ-013 out_valid SHALL be 1 exactly in BUSY and FULL; in_ready SHALL be 1 exactly in EMPTY and BUSY, except under REQ-022.
REQ-014 EMPTY: upstream transfer -> in_data into OR, go to BUSY; otherwise stay.
REQ-015 BUSY: upstream and downstream transfer on the same edge -> in_data into OR, stay BUSY.
REQ-016 BUSY: upstream transfer only -> in_data into SR, go to FULL, OR unchanged.
REQ-017 BUSY: downstream transfer only -> go to EMPTY.
REQ-018 FULL: downstream transfer -> SR into OR, go to BUSY; no upstream transfer is possible in FULL; otherwise hold.
REQ-019 Latency in_data to out_data SHALL be 1 clock from an upstream transfer into an empty OR; sustained throughput SHALL be one transfer per clock when out_ready is held 1.
REQ-020 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-021 out_data and OR SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-022 While areset=1 on an edge: state SHALL go to EMPTY, out_valid SHALL be 0, in_ready SHALL be 0, sts_count SHALL be 0; OR and SR contents SHALL be don't-care.
REQ-023 in_ready SHALL become 1 on the first rising edge with areset=0.
REQ-024 Reset asserted in BUSY or FULL SHALL discard held payloads; no downstream transfer SHALL follow from pre-reset data.
REQ-025 in_valid and out_ready SHALL be ignored on edges where areset=1.

Configuration
REQ-026 Macro SKID_BUFFER_COUNT_EN defined: sts_count port SHALL exist, increment by 1 on each downstream transfer, wrap 0xFFFFFFFF -> 0x00000000, reset to 0.
REQ-027 Macro SKID_BUFFER_COUNT_EN undefined: sts_count port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, then in_valid=1, in_data=0x11, out_ready=1 -> out_valid=1, out_data=0x11 one edge after the upstream transfer; in_ready=1 throughout.
REQ-029 out_ready=0, send 0xA1, 0xA2 -> state FULL, in_ready=0, out_data=0xA1 held stable; raise out_ready -> 0xA1 then 0xA2 out on consecutive edges, in_ready back to 1 after first.
REQ-030 Streaming 0x00..0xFF with in_valid=1, out_ready=1 -> 256 transfers in 256 consecutive edges after initial 1-clock latency, in order.
REQ-031 Random in_valid and out_ready (50% each), 10000 words from counter source -> output sequence equals input sequence, no gaps or repeats.
REQ-032 areset=1 for one edge while FULL with 0xB1, 0xB2 held -> out_valid=0, in_ready=0, next edge in_ready=1; 0xB1, 0xB2 never appear downstream.
REQ-033 With SKID_BUFFER_COUNT_EN, counter preloaded to 0xFFFFFFFE via forced state, 3 downstream transfers -> sts_count 0xFFFFFFFF, 0x00000000, 0x00000001.
